// File: rtl/branch_resolution_unit.sv
// Branch resolution at the end of EX: checks each branch against its IF prediction,
// keeps the 2-bit direction table and queues BTB target updates for the BTB write port.
module branch_resolution_unit #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int BUFFER_SIZE   = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [BUFFER_SIZE-1:0]   i_pc,
  output logic                     o_pred_taken,
  input  logic                     i_ex_valid,
  input  logic [BUFFER_SIZE-1:0]   i_ex_pc,
  input  logic                     i_ex_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_ex_target,
  input  logic [ADDRESS_WIDTH-1:0] i_ex_fallthrough,
  input  logic                     i_ex_pred_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_ex_pred_target,
  output logic                     o_redirect,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_target,
  output logic                     o_btb_wr_en,
  output logic [BUFFER_SIZE-1:0]   o_btb_pc,
  output logic [ADDRESS_WIDTH-1:0] o_btb_target,
  input  logic                     i_btb_ready,
  output logic                     o_stall,
  output logic                     o_overflow
);

  localparam int unsigned ENTRIES = 1 << BUFFER_SIZE;
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);

  // ---------------- direction table ----------------
  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;

  always_comb begin
    ctr_cur = ctr_q[i_ex_pc];
    ctr_d   = ctr_cur;
    if (i_ex_taken) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (i_ex_valid) begin
      ctr_q[i_ex_pc] <= ctr_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign o_pred_taken = ctr_q[i_pc][1];

  // ---------------- mispredict / redirect ----------------
  logic                     mis;
  logic                     redirect_q;
  logic [ADDRESS_WIDTH-1:0] redirect_target_q;
  logic                     tgt_diff;

  assign tgt_diff = (i_ex_pred_target != i_ex_target);
  assign mis      = i_ex_valid &&
                    ((i_ex_taken != i_ex_pred_taken) || (i_ex_taken && tgt_diff));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      redirect_q        <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      redirect_q <= mis;
      if (mis) redirect_target_q <= i_ex_taken ? i_ex_target : i_ex_fallthrough;
    end
  end

  assign o_redirect        = redirect_q;
  assign o_redirect_target = redirect_target_q;

  // ---------------- BTB update FIFO ----------------
  logic [BUFFER_SIZE-1:0]   pc_mem_q  [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] tgt_mem_q [FIFO_DEPTH];
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     empty, full;
  logic                     enq_req, enq_acc, deq;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign enq_req = i_ex_valid && i_ex_taken && tgt_diff;
  assign deq     = !empty && i_btb_ready;
  // At full, a same-cycle pop frees the slot the push lands in.
  assign enq_acc = enq_req && (!full || deq);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (deq)     head_d = head_q + PW'(1);
    if (enq_acc) tail_d = tail_q + PW'(1);
    if (enq_acc && !deq)      count_d = count_q + CW'(1);
    else if (!enq_acc && deq) count_d = count_q - CW'(1);
    if (enq_req && !enq_acc)  overflow_d = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (enq_acc) begin
      pc_mem_q[tail_q]  <= i_ex_pc;
      tgt_mem_q[tail_q] <= i_ex_target;
    end
  end

  assign o_btb_wr_en  = deq;
  assign o_btb_pc     = empty ? '0 : pc_mem_q[head_q];
  assign o_btb_target = empty ? '0 : tgt_mem_q[head_q];
  assign o_stall      = full;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a per-cycle behavioural model and literal checks.
module tb_branch_resolution_unit;

  localparam int AW = 22;
  localparam int BS = 8;
  localparam int FD = 4;

  logic          clk;
  logic          rst;
  logic [BS-1:0] i_pc;
  logic          pred_taken;
  logic          ex_valid;
  logic [BS-1:0] ex_pc;
  logic          ex_taken;
  logic [AW-1:0] ex_tgt;
  logic [AW-1:0] ex_ft;
  logic          ex_ptaken;
  logic [AW-1:0] ex_ptgt;
  logic          redir;
  logic [AW-1:0] redir_tgt;
  logic          wr_en;
  logic [BS-1:0] btb_pc;
  logic [AW-1:0] btb_tgt;
  logic          btb_ready;
  logic          stall;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  branch_resolution_unit #(
    .ADDRESS_WIDTH(AW),
    .BUFFER_SIZE  (BS),
    .FIFO_DEPTH   (FD)
  ) dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_pc             (i_pc),
    .o_pred_taken     (pred_taken),
    .i_ex_valid       (ex_valid),
    .i_ex_pc          (ex_pc),
    .i_ex_taken       (ex_taken),
    .i_ex_target      (ex_tgt),
    .i_ex_fallthrough (ex_ft),
    .i_ex_pred_taken  (ex_ptaken),
    .i_ex_pred_target (ex_ptgt),
    .o_redirect       (redir),
    .o_redirect_target(redir_tgt),
    .o_btb_wr_en      (wr_en),
    .o_btb_pc         (btb_pc),
    .o_btb_target     (btb_tgt),
    .i_btb_ready      (btb_ready),
    .o_stall          (stall),
    .o_overflow       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [BS-1:0] pc;
    logic [AW-1:0] tgt;
  } ent_t;

  int      mctr [256];
  ent_t    mq [$];
  bit      movf;
  bit      mredir;
  logic [AW-1:0] mredir_tgt;
  bit      m_deq, m_enq, m_full, m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mctr[i] = 1;
      mq.delete();
      movf       = 1'b0;
      mredir     = 1'b0;
      mredir_tgt = '0;
    end else begin
      m_deq  = (mq.size() > 0) && btb_ready;
      m_full = (mq.size() == FD);
      m_enq  = ex_valid && ex_taken && (ex_ptgt != ex_tgt);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) begin
        if (!m_full || m_deq) mq.push_back('{pc: ex_pc, tgt: ex_tgt});
        else movf = 1'b1;
      end
      m_mis  = ex_valid && ((ex_taken != ex_ptaken) || (ex_taken && ex_ptgt != ex_tgt));
      mredir = m_mis;
      if (m_mis) mredir_tgt = ex_taken ? ex_tgt : ex_ft;
      if (ex_valid) begin
        if (ex_taken) mctr[ex_pc] = (mctr[ex_pc] >= 3) ? 3 : mctr[ex_pc] + 1;
        else          mctr[ex_pc] = (mctr[ex_pc] <= 0) ? 0 : mctr[ex_pc] - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_pred_taken", 32'(pred_taken), 32'(mctr[i_pc] >= 2));
    chk("m_redirect", 32'(redir), 32'(mredir));
    if (mredir) chk("m_redirect_target", 32'(redir_tgt), 32'(mredir_tgt));
    chk("m_btb_wr_en", 32'(wr_en), 32'((mq.size() > 0) && btb_ready));
    if ((mq.size() > 0) && btb_ready) begin
      chk("m_btb_pc", 32'(btb_pc), 32'(mq[0].pc));
      chk("m_btb_target", 32'(btb_tgt), 32'(mq[0].tgt));
    end
    chk("m_stall", 32'(stall), 32'(mq.size() == FD));
    chk("m_overflow", 32'(ovf), 32'(movf));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [BS-1:0] pc, input logic tk, input logic ptk,
                    input logic [AW-1:0] tgt, input logic [AW-1:0] ptgt,
                    input logic [AW-1:0] ft);
    ex_valid  = 1'b1;
    ex_pc     = pc;
    ex_taken  = tk;
    ex_ptaken = ptk;
    ex_tgt    = tgt;
    ex_ptgt   = ptgt;
    ex_ft     = ft;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_tgt = '0; ex_ft = '0; ex_ptaken = 1'b0; ex_ptgt = '0; btb_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    i_pc = 8'h00; #1 chk("init_pred_00", 32'(pred_taken), 32'd0);
    i_pc = 8'hFF; #1 chk("init_pred_ff", 32'(pred_taken), 32'd0);

    // counter saturation at 0x12
    i_pc = 8'h12;
    br(8'h12, 1'b1, 1'b1, 22'h000100, 22'h000100, 22'h000104);
    repeat (4) cyc();
    idle();
    chk("sat_taken", 32'(pred_taken), 32'd1);
    br(8'h12, 1'b0, 1'b0, 22'h000100, 22'h000100, 22'h000104);
    cyc(); chk("nt_from_3", 32'(pred_taken), 32'd1);
    cyc(); chk("nt_to_1", 32'(pred_taken), 32'd0);
    repeat (2) cyc();
    br(8'h12, 1'b1, 1'b0, 22'h000100, 22'h000100, 22'h000104);
    cyc(); idle();
    chk("sat_floor", 32'(pred_taken), 32'd0);
    cyc();

    // direction mispredicts
    br(8'h20, 1'b1, 1'b0, 22'h000400, 22'h000400, 22'h000104);
    cyc(); idle();
    chk("dir_redir", 32'(redir), 32'd1);
    chk("dir_redir_tgt", 32'(redir_tgt), 32'h000400);
    cyc(); chk("dir_redir_once", 32'(redir), 32'd0);
    btb_ready = 1'b1; #1 chk("dir_no_enq", 32'(wr_en), 32'd0);
    btb_ready = 1'b0;
    br(8'h21, 1'b0, 1'b1, 22'h000999, 22'h000888, 22'h000104);
    cyc(); idle();
    chk("nt_redir", 32'(redir), 32'd1);
    chk("nt_redir_tgt", 32'(redir_tgt), 32'h000104);
    cyc(); chk("nt_redir_once", 32'(redir), 32'd0);
    chk("nt_no_enq_stall", 32'(stall), 32'd0);

    // back-to-back mispredicts
    br(8'h22, 1'b1, 1'b0, 22'h000500, 22'h000500, 22'h000108);
    cyc();
    br(8'h23, 1'b0, 1'b1, 22'h000000, 22'h000000, 22'h00010C);
    chk("b2b_first_tgt", 32'(redir_tgt), 32'h000500);
    cyc(); idle();
    chk("b2b_second", 32'(redir), 32'd1);
    chk("b2b_second_tgt", 32'(redir_tgt), 32'h00010C);
    cyc();

    // target mispredict and BTB write
    btb_ready = 1'b1;
    br(8'h05, 1'b1, 1'b1, 22'h000300, 22'h000200, 22'h000108);
    #1 chk("no_bypass", 32'(wr_en), 32'd0);
    cyc(); idle();
    chk("tgt_redir", 32'(redir), 32'd1);
    chk("tgt_wr_en", 32'(wr_en), 32'd1);
    chk("tgt_wr_pc", 32'(btb_pc), 32'h05);
    chk("tgt_wr_tgt", 32'(btb_tgt), 32'h000300);
    cyc(); chk("tgt_wr_once", 32'(wr_en), 32'd0);
    btb_ready = 1'b0;

    // fill, overflow, drain
    for (int k = 0; k < 4; k++) begin
      br(8'(8'h31 + k), 1'b1, 1'b1, 22'(22'h001000 + k), 22'h000000, 22'h000040);
      cyc();
    end
    idle();
    chk("full_stall", 32'(stall), 32'd1);
    br(8'h35, 1'b1, 1'b1, 22'h001004, 22'h000000, 22'h000040);
    cyc(); idle();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_stall", 32'(stall), 32'd1);
    btb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_wr", 32'(wr_en), 32'd1);
      chk("drain_pc", 32'(btb_pc), 32'(8'h31 + k));
      chk("drain_tgt", 32'(btb_tgt), 32'(22'h001000 + k));
      cyc();
      if (k == 0) chk("stall_after_pop", 32'(stall), 32'd0);
    end
    #1 chk("drain_empty", 32'(wr_en), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    btb_ready = 1'b0;

    // async reset with 3 queued
    for (int k = 0; k < 3; k++) begin
      br(8'(8'h50 + k), 1'b1, 1'b1, 22'(22'h002000 + k), 22'h000000, 22'h000040);
      cyc();
    end
    idle();
    btb_ready = 1'b1;
    #2 chk("pre_reset_wr", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_redir", 32'(redir), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    btb_ready = 1'b0;
    i_pc = 8'h00; #1 chk("rst_pred_00", 32'(pred_taken), 32'd0);
    i_pc = 8'hFF; #1 chk("rst_pred_ff", 32'(pred_taken), 32'd0);
    i_pc = 8'h05; #1 chk("rst_pred_05", 32'(pred_taken), 32'd0);
    cyc();

    // enqueue at full with simultaneous dequeue
    for (int k = 0; k < 4; k++) begin
      br(8'(8'h41 + k), 1'b1, 1'b1, 22'(22'h003000 + k), 22'h000000, 22'h000040);
      cyc();
    end
    idle();
    chk("full2_stall", 32'(stall), 32'd1);
    br(8'h45, 1'b1, 1'b1, 22'h003004, 22'h000000, 22'h000040);
    btb_ready = 1'b1;
    cyc(); idle();
    chk("simul_stall", 32'(stall), 32'd1);
    chk("simul_no_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("simul_wr", 32'(wr_en), 32'd1);
      chk("simul_pc", 32'(btb_pc), 32'(8'h42 + k));
      chk("simul_tgt", 32'(btb_tgt), 32'(22'h003001 + k));
      cyc();
    end
    #1 chk("simul_empty", 32'(wr_en), 32'd0);
    btb_ready = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Sits at the end of EX. Compares each resolved branch against the prediction made in IF.
- On a mispredict it raises a one-cycle redirect/flush to IF.
- Maintains a 2-bit saturating direction table, read combinationally by IF.
- Acts as the writer side of the branch target buffer: target updates are queued in a small FIFO and drained through the buffer's write port.

Parameters:
- ADDRESS_WIDTH, 22, width of a branch target / fetch address.
- BUFFER_SIZE, 8, index width; both the direction table and the BTB have 2**BUFFER_SIZE entries.
- FIFO_DEPTH, 4, BTB update queue entries (power of two, >=2).

Ports:
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_pc  in  BUFFER_SIZE  IF-stage table index for direction lookup.
- o_pred_taken  out  1  direction prediction for i_pc (combinational).
- i_ex_valid  in  1  a branch resolves in EX this cycle.
- i_ex_pc  in  BUFFER_SIZE  table/BTB index of the resolving branch.
- i_ex_taken  in  1  actual branch direction.
- i_ex_target  in  ADDRESS_WIDTH  actual taken target.
- i_ex_fallthrough  in  ADDRESS_WIDTH  sequential address after the branch.
- i_ex_pred_taken  in  1  direction predicted in IF, piped with the instruction.
- i_ex_pred_target  in  ADDRESS_WIDTH  BTB target read in IF, piped with the instruction.
- o_redirect  out  1  one-cycle mispredict pulse; IF reloads the PC and younger stages flush.
- o_redirect_target  out  ADDRESS_WIDTH  correct next fetch address.
- o_btb_wr_en  out  1  BTB write strobe.
- o_btb_pc  out  BUFFER_SIZE  BTB write index.
- o_btb_target  out  ADDRESS_WIDTH  BTB write data.
- i_btb_ready  in  1  BTB write port available this cycle.
- o_stall  out  1  update FIFO full; EX must hold the next branch.
- o_overflow  out  1  sticky: a BTB update was dropped.

Behaviour:
- Reset (async, any time including mid-operation):
  - All direction counters = 2'b01 (weakly not-taken).
  - FIFO emptied; head/tail/count = 0.
  - o_redirect = 0, o_redirect_target = 0, o_overflow = 0.
  - o_btb_wr_en = 0, o_stall = 0.
  - o_btb_pc and o_btb_target are don't-care while empty; RTL drives 0.
- Direction lookup:
  - o_pred_taken = counter[i_pc][1], combinational.
  - When i_pc == i_ex_pc in the same cycle as an update, the old (pre-update) value is returned.
- Counter update, on the edge where i_ex_valid = 1:
  - Taken: counter = min(counter + 1, 3).
  - Not taken: counter = max(counter - 1, 0).
  - Never wraps.
  - Updates even when o_stall or the enqueue is dropped.
- Mispredict detection, mis = i_ex_valid and any of:
  - (i_ex_taken != i_ex_pred_taken), or
  - (i_ex_taken and i_ex_pred_target != i_ex_target).
- Redirect, registered with 1-cycle latency:
  - o_redirect = mis of the previous cycle; pulse exactly one cycle per mispredict.
  - o_redirect_target = i_ex_taken ? i_ex_target : i_ex_fallthrough, captured on the same edge.
  - Back-to-back mispredicts give back-to-back pulses, each with its own target.
- Enqueue condition: i_ex_valid and i_ex_taken and (i_ex_pred_target != i_ex_target).
  - Entry = {i_ex_pc, i_ex_target}.
  - Not-taken branches never enqueue.
- Dequeue:
  - o_btb_wr_en = !empty and i_btb_ready.
  - o_btb_pc / o_btb_target = FIFO head, combinational.
  - Head pops on the edge where o_btb_wr_en = 1.
  - An entry enqueued at edge N can be written no earlier than cycle N+1.
  - Entries drain strictly in order; no coalescing of duplicate indices.
- o_stall = (count == FIFO_DEPTH).
- Full with simultaneous dequeue: the enqueue is accepted and count is unchanged.
- Full without dequeue and an enqueue request: the entry is dropped and o_overflow sets. o_overflow clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH and is FIFO_DEPTH+1 states wide.
- Empty with simultaneous enqueue: no bypass; o_btb_wr_en stays 0 that cycle.

Test Plan:
- Reset state: assert i_Reset mid-run with 3 FIFO entries queued -> immediately o_btb_wr_en = 0, o_redirect = 0, o_stall = 0. After release, o_pred_taken = 0 for i_pc = 0x00 and 0xFF.
- Counter saturation: 4x i_ex_valid, taken, i_ex_pc = 0x12 -> counter 01→10→11→11, o_pred_taken(0x12) = 1. Then 4x not-taken -> 10→01→00→00, o_pred_taken = 0.
- Direction mispredict: pred_taken = 0, taken = 1, target = 0x000400, pred_target = 0x000400 -> o_redirect = 1 next cycle only, o_redirect_target = 0x000400, no enqueue. Repeat with taken = 0, pred_taken = 1, fallthrough = 0x000104 -> redirect target 0x000104.
- Target mispredict and BTB write: taken = 1, pred_taken = 1, pred_target = 0x000200, target = 0x000300, i_ex_pc = 0x05, i_btb_ready = 1 -> o_redirect next cycle; o_btb_wr_en = 1 with pc 0x05, target 0x000300 in cycle N+1, for exactly one cycle.
- FIFO full and overflow: i_btb_ready = 0, 4 target mispredicts -> o_stall = 1. A 5th -> dropped, o_overflow = 1, count stays 4. Raise i_btb_ready -> 4 writes in order, o_stall deasserts after the first pop.
- Simultaneous enqueue/dequeue at full: count = 4, i_btb_ready = 1, enqueue -> accepted, count stays 4, o_overflow stays 0, new entry written last.
